// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI clock sequencer.
// SPI_SEQ_CS_GUARD_EN widens the chip-select setup/hold guard from 1 to 2 cycles.
package spi_seq_pkg;

`ifdef SPI_SEQ_CS_GUARD_EN
    localparam int GUARD = 2;
`else
    localparam int GUARD = 1;
`endif

    localparam int DIV_W   = 3;
    localparam int GUARD_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN,
        ST_HOLD,
        ST_DONE
    } spi_seq_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o
);

    int  cand;
    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr_i) + k) % N_REQ;
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/spi_clock_sequencer.sv
// Arbitrates requesters onto one SPI clock generator and frames each transfer.
// Define SPI_SEQ_CS_GUARD_EN for 2-cycle chip-select setup/hold (default 1).
module spi_clock_sequencer
    import spi_seq_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int LEN_W = 6
) (
    input  logic                   clockIn,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] req_bits,
    input  logic [N_REQ*DIV_W-1:0] req_divider,
    input  logic [N_REQ-1:0]       req_polarity,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic [N_REQ-1:0]       cs_n,
    output logic                   busy,
    output logic                   cg_enable,
    output logic [DIV_W-1:0]       cg_divider,
    output logic                   cg_polarity,
    input  logic                   cg_sync
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_REQ - 1);

    spi_seq_state_t     state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [GUARD_W-1:0] guard_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   done_q;
    logic [N_REQ-1:0]   cs_n_q;
    logic               busy_q;
    logic               en_q;
    logic [DIV_W-1:0]   div_q;
    logic               pol_q;

    logic [N_REQ-1:0]   sel_oh;
    logic [IDX_W-1:0]   sel_idx;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .grant_o (sel_oh),
        .idx_o   (sel_idx)
    );

    // Request inputs are only looked at in IDLE; everything else runs off latched copies.
    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            guard_q  <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            cs_n_q   <= '1;
            busy_q   <= 1'b0;
            en_q     <= 1'b0;
            div_q    <= '0;
            pol_q    <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q <= ST_SETUP;
                        busy_q  <= 1'b1;
                        grant_q <= sel_oh;
                        cs_n_q  <= ~sel_oh;
                        idx_q   <= sel_idx;
                        cnt_q   <= req_bits[sel_idx*LEN_W +: LEN_W];
                        div_q   <= req_divider[sel_idx*DIV_W +: DIV_W];
                        pol_q   <= req_polarity[sel_idx];
                        guard_q <= GUARD_LAST;
                    end
                end
                ST_SETUP: begin
                    if (guard_q != '0) begin
                        guard_q <= guard_q - 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_HOLD;
                        guard_q <= GUARD_LAST;
                    end else begin
                        state_q <= ST_RUN;
                        en_q    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cg_sync) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == LEN_W'(1)) begin
                            state_q <= ST_HOLD;
                            en_q    <= 1'b0;
                            guard_q <= GUARD_LAST;
                        end
                    end
                end
                ST_HOLD: begin
                    if (guard_q != '0) begin
                        guard_q <= guard_q - 1'b1;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= grant_q;
                    end
                end
                ST_DONE: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    grant_q  <= '0;
                    cs_n_q   <= '1;
                    rr_ptr_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign cs_n        = cs_n_q;
    assign busy        = busy_q;
    assign cg_enable   = en_q;
    assign cg_divider  = div_q;
    assign cg_polarity = pol_q;

endmodule

// File: tb/tb_spi_clock_sequencer.sv
// Directed bench for spi_clock_sequencer with a stub generator pulsing sync every 4 enabled cycles.
module tb_spi_clock_sequencer;

`ifdef SPI_SEQ_CS_GUARD_EN
    localparam int G = 2;
`else
    localparam int G = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [11:0] req_bits;
    logic [5:0]  req_divider;
    logic [1:0]  req_polarity;
    logic [1:0]  grant, done, cs_n;
    logic        busy, cg_enable, cg_polarity;
    logic [2:0]  cg_divider;
    logic        cg_sync = 1'b0;

    int checks = 0;
    int errors = 0;
    int sync_cnt = 0;

    always #5 clk = ~clk;

    spi_clock_sequencer #(.N_REQ(2), .LEN_W(6)) dut (
        .clockIn      (clk),
        .reset        (reset),
        .req          (req),
        .req_bits     (req_bits),
        .req_divider  (req_divider),
        .req_polarity (req_polarity),
        .grant        (grant),
        .done         (done),
        .cs_n         (cs_n),
        .busy         (busy),
        .cg_enable    (cg_enable),
        .cg_divider   (cg_divider),
        .cg_polarity  (cg_polarity),
        .cg_sync      (cg_sync)
    );

    always @(posedge clk) begin
        #1;
        if (!cg_enable) begin
            sync_cnt = 0;
            cg_sync  = 1'b0;
        end else begin
            sync_cnt = sync_cnt + 1;
            cg_sync  = (sync_cnt % 4 == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_cs_n"}, 32'(cs_n), 32'h3);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_en"}, 32'(cg_enable), 32'h0);
        chk({tag, "_div"}, 32'(cg_divider), 32'h0);
        chk({tag, "_pol"}, 32'(cg_polarity), 32'h0);
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (grant == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_grant_timeout"}, 32'(n < 20), 32'h1);
    endtask

    // Runs one transfer from grant to the cycle after done; returns in IDLE at a negedge.
    task automatic xfer(input string tag, input int idx, input int bits,
                        input logic [2:0] div, input logic pol, input bit perturb);
        logic [1:0] oh;
        logic [1:0] noh;
        int cyc, sync_n, en_n, first_en;
        bit hold_ok;
        oh = 2'b00;
        oh[idx] = 1'b1;
        noh = ~oh;
        wait_grant(tag);
        chk({tag, "_grant"}, 32'(grant), 32'(oh));
        chk({tag, "_cs_n"}, 32'(cs_n), 32'(noh));
        chk({tag, "_busy"}, 32'(busy), 32'h1);
        chk({tag, "_div"}, 32'(cg_divider), 32'(div));
        chk({tag, "_pol"}, 32'(cg_polarity), 32'(pol));
        chk({tag, "_en_at_grant"}, 32'(cg_enable), 32'h0);
        cyc = 0; sync_n = 0; en_n = 0; first_en = -1; hold_ok = 1'b1;
        while (done == 2'b00 && cyc < 1000) begin
            if (cg_enable && first_en < 0) first_en = cyc;
            if (cg_enable && cg_sync) sync_n++;
            if (cg_enable) en_n++;
            if (cg_divider !== div || cg_polarity !== pol || cs_n !== noh || grant !== oh)
                hold_ok = 1'b0;
            if (perturb && en_n == 6) begin
                req          = 2'b00;
                req_divider  = 6'b111111;
                req_polarity = ~req_polarity;
                req_bits     = 12'hFFF;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_cycles"}, 32'(cyc), 32'(2 * G + 4 * bits));
        chk({tag, "_sync_pulses"}, 32'(sync_n), 32'(bits));
        chk({tag, "_en_cycles"}, 32'(en_n), 32'(4 * bits));
        chk({tag, "_held_stable"}, 32'(hold_ok), 32'h1);
        if (bits > 0) begin
            chk({tag, "_setup_guard"}, 32'(first_en), 32'(G));
            chk({tag, "_hold_guard"}, 32'(cyc - first_en - en_n), 32'(G));
        end
        chk({tag, "_done"}, 32'(done), 32'(oh));
        chk({tag, "_cs_n_in_done"}, 32'(cs_n), 32'(noh));
        @(negedge clk);
        chk({tag, "_done_clr"}, 32'(done), 32'h0);
        chk({tag, "_grant_clr"}, 32'(grant), 32'h0);
        chk({tag, "_cs_n_clr"}, 32'(cs_n), 32'h3);
        chk({tag, "_busy_clr"}, 32'(busy), 32'h0);
    endtask

    initial begin
        reset        = 1'b0;
        req          = 2'b00;
        req_bits     = '0;
        req_divider  = '0;
        req_polarity = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b1;
        @(negedge clk);

        // Single requester 0: 8 bits, divider 2, polarity 1.
        req_bits[5:0]   = 6'd8;
        req_divider[2:0] = 3'd2;
        req_polarity[0] = 1'b1;
        req = 2'b01;
        xfer("single0", 0, 8, 3'd2, 1'b1, 1'b0);
        req = 2'b00;

        // Pointer is now 1; reset brings it back so the pair starts at 0.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Both requesting: strict alternation 0,1,0,1.
        req_bits        = {6'd3, 6'd2};
        req_divider     = {3'd5, 3'd2};
        req_polarity    = 2'b01;
        req = 2'b11;
        xfer("rr_a0", 0, 2, 3'd2, 1'b1, 1'b0);
        xfer("rr_a1", 1, 3, 3'd5, 1'b0, 1'b0);
        xfer("rr_b0", 0, 2, 3'd2, 1'b1, 1'b0);
        xfer("rr_b1", 1, 3, 3'd5, 1'b0, 1'b0);
        req = 2'b00;

        // Zero length on requester 1.
        req_bits[11:6] = 6'd0;
        req = 2'b10;
        xfer("zero1", 1, 0, 3'd5, 1'b0, 1'b0);
        req = 2'b00;

        // Requester 1 drops req and its settings change mid-RUN.
        req_bits[11:6] = 6'd4;
        req = 2'b10;
        xfer("drop1", 1, 4, 3'd5, 1'b0, 1'b1);
        req          = 2'b00;
        req_bits     = {6'd3, 6'd2};
        req_divider  = {3'd5, 3'd2};
        req_polarity = 2'b01;
        repeat (3) @(negedge clk);
        chk("idle_pol_held", 32'(cg_polarity), 32'h0);
        chk("idle_div_held", 32'(cg_divider), 32'h5);
        chk("idle_no_grant", 32'(grant), 32'h0);

        // Advance pointer to 1, then reset in the middle of requester 1's RUN.
        req = 2'b01;
        xfer("pre_rst0", 0, 2, 3'd2, 1'b1, 1'b0);
        req = 2'b10;
        wait_grant("rst_run");
        chk("rst_run_grant", 32'(grant), 32'h2);
        begin
            int n = 0;
            while (!cg_enable && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("rst_run_en_timeout", 32'(n < 20), 32'h1);
        end
        repeat (3) @(negedge clk);
        chk("rst_run_en_before", 32'(cg_enable), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        @(negedge clk);
        chk("mid_rst_no_done", 32'(done), 32'h0);
        reset = 1'b1;
        req   = 2'b11;
        xfer("post_rst0", 0, 2, 3'd2, 1'b1, 1'b0);
        xfer("post_rst1", 1, 3, 3'd5, 1'b0, 1'b0);
        req = 2'b00;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
